fetch_byte_queue: RTL and testbench



---
 rtl/fetch_byte_queue.sv | 191 +++++++++++++++++++
 tb/tb_fetch_byte_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_byte_queue.sv
// Instruction-fetch byte queue: sequential word reads into a circular byte buffer, variable-length retire.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_byte_queue #(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned DEPTH_BYTES   = 16,
   parameter int unsigned WINDOW_BYTES  = 8,
   parameter logic [ADDRESS_WIDTH-1:0] START_ADDRESS = '0
) (
   input  logic                                   clk,
   input  logic                                   reset,
   output logic [ADDRESS_WIDTH-1:0]               o_mem_address,
   output logic                                   o_mem_cmd,
   output logic                                   o_mem_valid,
   input  logic                                   i_mem_ready,
   input  logic [DATA_WIDTH-1:0]                  i_mem_data,
   input  logic                                   i_mem_res_valid,
   output logic [WINDOW_BYTES*8-1:0]              o_window,
   output logic [$clog2(WINDOW_BYTES+1)-1:0]      o_window_count,
   output logic [ADDRESS_WIDTH-1:0]               o_pc,
   input  logic                                   i_consume_valid,
   input  logic [$clog2(WINDOW_BYTES+1)-1:0]      i_consume_bytes,
   input  logic                                   i_redirect,
   input  logic [ADDRESS_WIDTH-1:0]               i_redirect_address,
   output logic                                   o_consume_error
`ifdef FETCH_PERF_EN
  ,output logic [31:0]                            o_stall_cycles,
   output logic [31:0]                            o_words_fetched
`endif
);

   localparam int unsigned WB    = DATA_WIDTH / 8;
   localparam int unsigned PTR_W = $clog2(DEPTH_BYTES);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned WC_W  = $clog2(WINDOW_BYTES + 1);
   localparam logic        MEM_CMD_READ = 1'b0;
   localparam logic [ADDRESS_WIDTH-1:0] WB_A        = ADDRESS_WIDTH'(WB);
   localparam logic [ADDRESS_WIDTH-1:0] START_FETCH = START_ADDRESS - (START_ADDRESS % WB_A);
   localparam logic [CNT_W-1:0]         START_SKIP  = CNT_W'(START_ADDRESS % WB_A);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DISCARD} state_t;

   state_t                  state_q, state_d;
   logic [7:0]              mem_q [DEPTH_BYTES];
   logic [7:0]              mem_d [DEPTH_BYTES];
   logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, fetch_q, fetch_d;
   logic [CNT_W-1:0]        skip_q, skip_d;
   logic                    err_q, err_d;

   logic [WC_W-1:0]         win_cnt;
   logic [WC_W-1:0]         rd_cnt;
   logic [CNT_W-1:0]        wr_cnt;
   logic [CNT_W-1:0]        free_cnt;
   logic [PTR_W-1:0]        wr_idx;
   logic                    fill;

   // Decoder window: head bytes, zero beyond the valid count
   always_comb begin
      o_window = '0;
      if (count_q >= CNT_W'(WINDOW_BYTES)) win_cnt = WC_W'(WINDOW_BYTES);
      else                                 win_cnt = WC_W'(count_q);
      for (int unsigned k = 0; k < WINDOW_BYTES; k++) begin
         if (WC_W'(k) < win_cnt) o_window[8*k +: 8] = mem_q[PTR_W'(head_q + PTR_W'(k))];
      end
   end

   // Next-state: fetch FSM, queue fill/retire, redirect override
   always_comb begin
      state_d  = state_q;
      mem_d    = mem_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      pc_d     = pc_q;
      fetch_d  = fetch_q;
      skip_d   = skip_q;
      err_d    = 1'b0;
      rd_cnt   = '0;
      wr_cnt   = '0;
      wr_idx   = '0;
      fill     = 1'b0;
      free_cnt = CNT_W'(DEPTH_BYTES) - count_q;

      case (state_q)
         ST_IDLE:    if (free_cnt >= CNT_W'(WB)) state_d = ST_REQ;
         ST_REQ:     if (i_mem_ready) state_d = ST_WAIT;
         ST_WAIT: begin
            if (i_mem_res_valid) begin
               fill    = 1'b1;
               wr_cnt  = CNT_W'(WB) - skip_q;
               for (int unsigned k = 0; k < WB; k++) begin
                  if (CNT_W'(k) >= skip_q) begin
                     wr_idx        = PTR_W'(tail_q + PTR_W'(k) - PTR_W'(skip_q));
                     mem_d[wr_idx] = i_mem_data[8*k +: 8];
                  end
               end
               tail_d  = PTR_W'(tail_q + PTR_W'(wr_cnt));
               skip_d  = '0;
               fetch_d = fetch_q + WB_A;
               state_d = ST_IDLE;
            end
         end
         ST_DISCARD: if (i_mem_res_valid) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      // Over-long consume retires only what the window shows
      if (i_consume_valid) begin
         if (i_consume_bytes > win_cnt) begin
            rd_cnt = win_cnt;
            err_d  = 1'b1;
         end else begin
            rd_cnt = i_consume_bytes;
         end
      end
      head_d  = PTR_W'(head_q + PTR_W'(rd_cnt));
      pc_d    = pc_q + ADDRESS_WIDTH'(rd_cnt);
      count_d = count_q + wr_cnt - CNT_W'(rd_cnt);

      if (i_redirect) begin
         fill    = 1'b0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         err_d   = 1'b0;
         pc_d    = i_redirect_address;
         fetch_d = i_redirect_address - (i_redirect_address % WB_A);
         skip_d  = CNT_W'(i_redirect_address % WB_A);
         case (state_q)
            ST_REQ:     state_d = i_mem_ready ? ST_DISCARD : ST_IDLE;
            ST_WAIT,
            ST_DISCARD: state_d = i_mem_res_valid ? ST_IDLE : ST_DISCARD;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         pc_q    <= START_ADDRESS;
         fetch_q <= START_FETCH;
         skip_q  <= START_SKIP;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         pc_q    <= pc_d;
         fetch_q <= fetch_d;
         skip_q  <= skip_d;
         err_q   <= err_d;
      end
   end

   // Byte storage needs no reset: bytes beyond count are never exposed
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef FETCH_PERF_EN
   logic [31:0] stall_q, words_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         words_q <= '0;
      end else begin
         if (win_cnt < WC_W'(WINDOW_BYTES) && !i_redirect) stall_q <= stall_q + 32'd1;
         if (fill) words_q <= words_q + 32'd1;
      end
   end

   assign o_stall_cycles  = stall_q;
   assign o_words_fetched = words_q;
`endif

   assign o_mem_address   = fetch_q;
   assign o_mem_cmd       = MEM_CMD_READ;
   assign o_mem_valid     = (state_q == ST_REQ);
   assign o_window_count  = win_cnt;
   assign o_pc            = pc_q;
   assign o_consume_error = err_q;

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Randomized bench for fetch_byte_queue against a byte-stream reference model and a latency memory model.
module tb_fetch_byte_queue;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned WB   = DW / 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned WIN  = 8;
   localparam int unsigned WC_W = $clog2(WIN + 1);

   logic            clk = 1'b0;
   logic            reset;
   logic [AW-1:0]   o_mem_address;
   logic            o_mem_cmd;
   logic            o_mem_valid;
   logic            i_mem_ready;
   logic [DW-1:0]   i_mem_data;
   logic            i_mem_res_valid;
   logic [WIN*8-1:0] o_window;
   logic [WC_W-1:0] o_window_count;
   logic [AW-1:0]   o_pc;
   logic            i_consume_valid;
   logic [WC_W-1:0] i_consume_bytes;
   logic            i_redirect;
   logic [AW-1:0]   i_redirect_address;
   logic            o_consume_error;
`ifdef FETCH_PERF_EN
   logic [31:0]     o_stall_cycles;
   logic [31:0]     o_words_fetched;
`endif

   always #5 clk = ~clk;

   fetch_byte_queue dut (
      .clk                (clk),
      .reset              (reset),
      .o_mem_address      (o_mem_address),
      .o_mem_cmd          (o_mem_cmd),
      .o_mem_valid        (o_mem_valid),
      .i_mem_ready        (i_mem_ready),
      .i_mem_data         (i_mem_data),
      .i_mem_res_valid    (i_mem_res_valid),
      .o_window           (o_window),
      .o_window_count     (o_window_count),
      .o_pc               (o_pc),
      .i_consume_valid    (i_consume_valid),
      .i_consume_bytes    (i_consume_bytes),
      .i_redirect         (i_redirect),
      .i_redirect_address (i_redirect_address),
      .o_consume_error    (o_consume_error)
`ifdef FETCH_PERF_EN
     ,.o_stall_cycles     (o_stall_cycles),
      .o_words_fetched    (o_words_fetched)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: expected byte stream from the current PC onward
   logic [7:0]  mq[$];
   logic [31:0] m_pc, m_fetch;
   int          m_skip;
   bit          m_err, m_stale;
   int          words_written;

   // Memory model: single pending read with programmable latency
   bit          pend;
   logic [31:0] pend_addr;
   int          timer;
   int          lat_min, lat_max;
   bit          rdy_rand;

   function automatic logic [7:0] mbyte(input logic [31:0] a);
      return (a[7:0] + 8'd1) ^ a[15:8];
   endfunction

   function automatic logic [31:0] mword(input logic [31:0] a);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = mbyte(a + 32'(k));
      return w;
   endfunction

   task automatic model_redirect(input logic [31:0] a);
      mq.delete();
      m_pc    = a;
      m_fetch = a & ~32'(WB - 1);
      m_skip  = int'(a % WB);
      m_err   = 1'b0;
   endtask

   task automatic step(input bit cv, input int cn, input bit rd, input logic [31:0] ra);
      logic [63:0] ew;
      int          wn, eff;
      bit          acc, res;
      wn = (mq.size() < WIN) ? mq.size() : WIN;
      ew = '0;
      for (int k = 0; k < wn; k++) ew[8*k +: 8] = mq[k];
      check("win_count", 64'(o_window_count), 64'(wn));
      check("window", o_window, ew);
      check("pc", 64'(o_pc), 64'(m_pc));
      check("consume_err", 64'(o_consume_error), 64'(m_err));

      i_mem_res_valid    = pend && (timer == 0);
      i_mem_data         = i_mem_res_valid ? mword(pend_addr) : $urandom;
      i_mem_ready        = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_consume_valid    = cv;
      i_consume_bytes    = WC_W'(cn);
      i_redirect         = rd;
      i_redirect_address = ra;

      acc = o_mem_valid && i_mem_ready;
      res = i_mem_res_valid;
      if (acc) begin
         check("one_outstanding", 64'(pend), 64'(0));
         if (!rd) check("req_addr", 64'(o_mem_address), 64'(m_fetch));
      end

      if (rd) begin
         m_stale = (pend && !res) || acc;
         model_redirect(ra);
      end else begin
         if (res) begin
            if (m_stale) m_stale = 1'b0;
            else begin
               for (int k = m_skip; k < WB; k++) mq.push_back(mbyte(pend_addr + 32'(k)));
               m_skip  = 0;
               m_fetch = m_fetch + 32'(WB);
               words_written++;
            end
         end
         m_err = 1'b0;
         if (cv) begin
            eff   = (cn > wn) ? wn : cn;
            m_err = (cn > wn);
            repeat (eff) void'(mq.pop_front());
            m_pc  = m_pc + 32'(eff);
         end
      end
      check("no_overflow", 64'(mq.size() > DEPTH), 64'(0));

      if (res) pend = 1'b0;
      else if (pend && timer > 0) timer--;
      if (acc) begin
         pend      = 1'b1;
         pend_addr = o_mem_address;
         timer     = $urandom_range(lat_min, lat_max) - 1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 0, 1'b0, 32'h0);
   endtask

   task automatic do_reset(input int cycles);
      reset           = 1'b1;
      i_mem_ready     = 1'b0;
      i_mem_res_valid = 1'b0;
      i_consume_valid = 1'b0;
      i_redirect      = 1'b0;
      pend            = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("rst_valid", 64'(o_mem_valid), 64'(0));
      check("rst_count", 64'(o_window_count), 64'(0));
      check("rst_window", o_window, 64'(0));
      check("rst_pc", 64'(o_pc), 64'(0));
      check("rst_err", 64'(o_consume_error), 64'(0));
      reset = 1'b0;
      model_redirect(32'h0);
      m_stale       = 1'b0;
      words_written = 0;
   endtask

   initial begin
      int          n;
      logic [31:0] prev, ra;
      reset = 1'b1;  i_mem_ready = 1'b0;  i_mem_data = '0;  i_mem_res_valid = 1'b0;
      i_consume_valid = 1'b0;  i_consume_bytes = '0;  i_redirect = 1'b0;  i_redirect_address = '0;
      pend = 1'b0;  timer = 0;  pend_addr = '0;
      lat_min = 1;  lat_max = 1;  rdy_rand = 1'b0;
      @(negedge clk);
      do_reset(4);

      // Fill from address 0 with no consume: queue fills and fetch stops
      idle(40);
      check("s1_window", o_window, 64'h0807060504030201);
      check("s1_count", 64'(o_window_count), 64'(8));
      check("s1_pc", 64'(o_pc), 64'(0));
      check("s1_words", 64'(words_written), 64'(DEPTH / WB));
      check("s1_stopped", 64'(o_mem_valid), 64'(0));

      step(1'b1, 4, 1'b0, 32'h0);
      n = 0;
      while (!o_mem_valid && n < 6) begin idle(1); n++; end
      check("s2_refill_latency", 64'(n <= 1), 64'(1));

      // Unaligned redirect
      step(1'b0, 0, 1'b1, 32'h6);
      n = 0;
      while (o_window_count == 0 && n < 20) begin idle(1); n++; end
      check("s3_count", 64'(o_window_count), 64'(2));
      check("s3_byte0", 64'(o_window[7:0]), 64'h07);
      check("s3_pc", 64'(o_pc), 64'(6));
      check("s3_window", o_window, 64'h0807);

      // Over-long consume
      step(1'b1, 5, 1'b0, 32'h0);
      check("s6_err", 64'(o_consume_error), 64'(1));
      check("s6_pc", 64'(o_pc), 64'(8));
      idle(1);
      check("s6_err_pulse", 64'(o_consume_error), 64'(0));

      // Steady 3-byte retire through pointer wrap
      step(1'b0, 0, 1'b1, 32'h0);
      idle(30);
      n = 0;
      while (o_pc < 32'd40 && n < 200) begin
         prev = o_pc;
         if (o_window_count >= WC_W'(3)) begin
            step(1'b1, 3, 1'b0, 32'h0);
            check("s4_pc_inc", 64'(o_pc), 64'(prev + 32'd3));
         end else idle(1);
         n++;
      end
      check("s4_reached", 64'(o_pc >= 32'd40), 64'(1));

      // Redirect while a 5-cycle read is outstanding
      lat_min = 5;  lat_max = 5;
      step(1'b0, 0, 1'b1, 32'h40);
      n = 0;
      while (!o_mem_valid && n < 20) begin idle(1); n++; end
      idle(1);
      step(1'b0, 0, 1'b1, 32'h102);
      repeat (3) begin
         idle(1);
         check("s5_empty", 64'(o_window_count), 64'(0));
      end
      n = 0;
      while (!o_mem_valid && n < 20) begin idle(1); n++; end
      check("s5_addr", 64'(o_mem_address), 64'h100);
      idle(20);

      // Random traffic with redirects, wrap addresses and one reset
      lat_min = 1;  lat_max = 6;  rdy_rand = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset(8);
         case ($urandom_range(0, 2))
            0:       ra = 32'($urandom_range(0, 64));
            1:       ra = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: ra = $urandom;
         endcase
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, WIN + 1)),
              $urandom_range(0, 99) < 3, ra);
      end
`ifdef FETCH_PERF_EN
      check("perf_words", 64'(o_words_fetched), 64'(words_written));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
